// File: rtl/cdb_arbiter_if.sv
// Common data bus interface between the functional-unit request side and the
// CDB arbiter: per-unit write requests with tag/data, and the arbitrated
// broadcast plus one-hot grant coming back.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_id;
    logic [DATA_W-1:0]         cdb_data;

    // Requesting side (reservation stations / load buffers).
    modport master (
        output req, req_tag, req_data,
        input  grant, cdb_valid, cdb_id, cdb_data
    );

    // Arbiter side.
    modport slave (
        input  req, req_tag, req_data,
        output grant, cdb_valid, cdb_id, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin single-grant arbiter for the Tomasulo common data bus.
// One eligible requester wins per cycle; its tag/data are broadcast from
// registers the following cycle together with a one-cycle one-hot grant.
// The unit granted last cycle is masked so it has a cycle to drop its request.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    cdb_arbiter_if.slave          bus,
    output logic                  err_zero_tag_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    // Registered state and outputs.
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic               valid_q,   valid_d;
    logic [TAG_W-1:0]   id_q,      id_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic               err_q,     err_d;

    // Combinational arbitration results.
    logic [NUM_REQ-1:0] elig_s;
    logic               zero_tag_s;
    logic               found_s;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   idx_s;
    logic [TAG_W-1:0]   win_tag_s;
    logic [DATA_W-1:0]  win_data_s;

    // Eligibility: requesting, non-zero tag, and not granted in the current cycle.
    always_comb begin
        elig_s     = {NUM_REQ{1'b0}};
        zero_tag_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
                if (bus.req_tag[i*TAG_W +: TAG_W] == {TAG_W{1'b0}}) begin
                    zero_tag_s = 1'b1;
                end else begin
                    elig_s[i] = ~grant_q[i];
                end
            end else begin
                elig_s[i] = 1'b0;
            end
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found_s    = 1'b0;
        win_s      = {PTR_W{1'b0}};
        win_tag_s  = {TAG_W{1'b0}};
        win_data_s = {DATA_W{1'b0}};
        idx_s      = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && elig_s[idx_s]) begin
                found_s    = 1'b1;
                win_s      = idx_s;
                win_tag_s  = bus.req_tag[idx_s*TAG_W +: TAG_W];
                win_data_s = bus.req_data[idx_s*DATA_W +: DATA_W];
            end else begin
                found_s    = found_s;
            end
            if (idx_s == LAST_IDX) begin
                idx_s = {PTR_W{1'b0}};
            end else begin
                idx_s = idx_s + PTR_W'(1);
            end
        end
    end

    // Next-state: broadcast the winner unless squashed; pointer moves past the winner.
    always_comb begin
        err_d = err_q | zero_tag_s;
        if (found_s && !flush_i) begin
            valid_d = 1'b1;
            id_d    = win_tag_s;
            data_d  = win_data_s;
            grant_d = NUM_REQ'(1) << win_s;
            if (win_s == LAST_IDX) begin
                rr_ptr_d = {PTR_W{1'b0}};
            end else begin
                rr_ptr_d = win_s + PTR_W'(1);
            end
        end else begin
            valid_d  = 1'b0;
            id_d     = {TAG_W{1'b0}};
            data_d   = {DATA_W{1'b0}};
            grant_d  = {NUM_REQ{1'b0}};
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q  <= {NUM_REQ{1'b0}};
            valid_q  <= 1'b0;
            id_q     <= {TAG_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            rr_ptr_q <= {PTR_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.cdb_valid  = valid_q;
    assign bus.cdb_id     = id_q;
    assign bus.cdb_data   = data_q;
    assign err_zero_tag_o = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter. Each row is one cycle of stimulus plus
// the outputs expected right after the posedge that samples it; expectations
// are queued when a row is driven and compared one cycle later.
module tb_cdb_arbiter;

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [2:0] req;
        logic [3:0] t0;
        logic [3:0] t1;
        logic [3:0] t2;
        logic [2:0] eg;     // expected grant
        logic [3:0] eid;    // expected cdb_id
        logic       eerr;   // expected err_zero_tag
    } row_t;

    typedef struct {
        logic [2:0]  grant;
        logic [3:0]  id;
        logic [63:0] data;
        logic        err;
        int          row;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    logic err_zero_tag;

    cdb_arbiter_if #(.NUM_REQ(3), .TAG_W(4), .DATA_W(64)) bus ();

    cdb_arbiter #(.NUM_REQ(3), .TAG_W(4), .DATA_W(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .bus            (bus),
        .err_zero_tag_o (err_zero_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row_no = 0;

    // Unique data word per (unit, tag) so a wrong data mux shows up.
    function automatic logic [63:0] dat(input logic [1:0] unit, input logic [3:0] tag);
        return {16'hDA7A, 14'h0, unit, 28'h0, tag};
    endfunction

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: actual %h required %h", name, row, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        check("grant",        e.row, 64'(bus.grant),     64'(e.grant));
        check("cdb_valid",    e.row, 64'(bus.cdb_valid), 64'(|e.grant));
        check("cdb_id",       e.row, 64'(bus.cdb_id),    64'(e.id));
        check("cdb_data",     e.row, bus.cdb_data,       e.data);
        check("err_zero_tag", e.row, 64'(err_zero_tag),  64'(e.err));
        check("grant_onehot", e.row, 64'($onehot0(bus.grant)), 64'd1);
    endtask

    // One cycle: compare the previous row's expectations, then drive this row.
    task automatic step(input row_t r);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        rst          = r.rst;
        flush        = r.flush;
        bus.req      = r.req;
        bus.req_tag  = {r.t2, r.t1, r.t0};
        bus.req_data = {dat(2'd2, r.t2), dat(2'd1, r.t1), dat(2'd0, r.t0)};
        e.grant = r.eg;
        e.id    = r.eid;
        e.err   = r.eerr;
        e.row   = row_no;
        case (r.eg)
            3'b001:  e.data = dat(2'd0, r.t0);
            3'b010:  e.data = dat(2'd1, r.t1);
            3'b100:  e.data = dat(2'd2, r.t2);
            default: e.data = 64'h0;
        endcase
        sb.push_back(e);
        row_no++;
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        bus.req      = 3'b000;
        bus.req_tag  = '0;
        bus.req_data = '0;

        //              rst   flush req     t0    t1    t2    eg      eid   eerr
        // Reset with all requesting, then round robin 1,4,6,1,4,6
        tbl.push_back('{1'b1, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b001, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b010, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b100, 4'd6, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b001, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b010, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b100, 4'd6, 1'b0});
        // Single requester: granted, masked next cycle, granted again
        tbl.push_back('{1'b0, 1'b0, 3'b010, 4'd1, 4'd4, 4'd6, 3'b010, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b010, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b010, 4'd1, 4'd4, 4'd6, 3'b010, 4'd4, 1'b0});
        // Wrap-around from rr_ptr=2 with units 0 and 2
        tbl.push_back('{1'b0, 1'b0, 3'b101, 4'd1, 4'd4, 4'd6, 3'b100, 4'd6, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b101, 4'd1, 4'd4, 4'd6, 3'b001, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        // Flush squashes, request stays pending and wins next cycle
        tbl.push_back('{1'b0, 1'b1, 3'b001, 4'd2, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b001, 4'd2, 4'd4, 4'd6, 3'b001, 4'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd2, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        // Broadcast on the bus during a flush cycle completes; new one squashed
        tbl.push_back('{1'b0, 1'b0, 3'b010, 4'd1, 4'd5, 4'd6, 3'b010, 4'd5, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b001, 4'd3, 4'd5, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd3, 4'd5, 4'd6, 3'b000, 4'd0, 1'b0});
        // Zero tag: never granted, sticky error
        tbl.push_back('{1'b0, 1'b0, 3'b100, 4'd1, 4'd4, 4'd0, 3'b000, 4'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 3'b100, 4'd1, 4'd4, 4'd0, 3'b000, 4'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd1, 4'd4, 4'd0, 3'b000, 4'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 3'b001, 4'd1, 4'd4, 4'd0, 3'b001, 4'd1, 1'b1});
        // Reset beats flush and requests, clears the sticky error
        tbl.push_back('{1'b1, 1'b1, 3'b111, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b0});
        // Zero-tag unit skipped while another unit still wins
        tbl.push_back('{1'b0, 1'b0, 3'b011, 4'd0, 4'd4, 4'd6, 3'b010, 4'd4, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 3'b000, 4'd0, 4'd4, 4'd6, 3'b000, 4'd0, 1'b1});

        foreach (tbl[i]) step(tbl[i]);

        // Hand-written sequence: flush held over two cycles with all units
        // requesting (rr_ptr=2 here), then released; unit 1 drops out later.
        step('{1'b0, 1'b1, 3'b111, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b1});
        step('{1'b0, 1'b1, 3'b111, 4'd1, 4'd4, 4'd6, 3'b000, 4'd0, 1'b1});
        step('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b100, 4'd6, 1'b1});
        step('{1'b0, 1'b0, 3'b111, 4'd1, 4'd4, 4'd6, 3'b001, 4'd1, 1'b1});
        step('{1'b0, 1'b0, 3'b101, 4'd1, 4'd4, 4'd6, 3'b100, 4'd6, 1'b1});
        step('{1'b0, 1'b0, 3'b101, 4'd7, 4'd4, 4'd8, 3'b001, 4'd7, 1'b1});
        step('{1'b0, 1'b0, 3'b000, 4'd7, 4'd4, 4'd8, 3'b000, 4'd0, 1'b1});

        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
